// File: rtl/irq_sched.sv
// irq_sched -- nine-channel interrupt scheduler with grant timeout.
//
// Rising edges on REQ set pending bits. While idle, the block picks one
// pending, unmasked channel and grants it (IRQ/ID). The grant ends on ACK,
// which clears the pending bit, or after TIMEOUT unacknowledged cycles,
// which leaves the pending bit set and pulses TMO.
//
// Optional feature macro: IRQ_SCHED_RR_EN
//   undefined : fixed priority, lowest channel index wins
//   defined   : round-robin, search starts after the last granted channel
//
// Ports
//   CK       in   clock, rising edge
//   RST      in   synchronous active-high reset
//   REQ      in   [8:0] interrupt request lines, channel 0 = bit 0
//   MASK_WE  in   mask write strobe
//   MASK_D   in   [8:0] mask write data, 1 = masked
//   MASK_Q   out  [8:0] current mask (reset: all masked)
//   PEND     out  [8:0] pending register
//   IRQ      out  grant valid
//   ID       out  [3:0] granted channel, 0..8
//   ACK      in   acknowledge for the current grant
//   TMO      out  one-cycle pulse when a grant times out
module irq_sched #(
   parameter int TIMEOUT = 15
) (
   input  logic       CK,
   input  logic       RST,
   input  logic [8:0] REQ,
   input  logic       MASK_WE,
   input  logic [8:0] MASK_D,
   output logic [8:0] MASK_Q,
   output logic [8:0] PEND,
   output logic       IRQ,
   output logic [3:0] ID,
   input  logic       ACK,
   output logic       TMO
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state, state_nxt;
   logic [8:0] req_q;
   logic [8:0] pend, pend_nxt;
   logic [8:0] mask;
   logic [3:0] id, id_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic       tmo_nxt;
   logic [8:0] req_rise;
   logic [8:0] eligible;
   logic [8:0] clr;
   logic [4:0] pick_res;
   logic [3:0] next_start;

   // Circular search over the nine channels starting at 'start'. Scanning
   // from the far end lets the closest hit overwrite the result last.
   function automatic logic [4:0] pick(input logic [8:0] elig, input logic [3:0] start);
      logic [4:0] res;
      logic [4:0] idx;
      res = '0;
      for (int k = 8; k >= 0; k--) begin
         idx = {1'b0, start} + 5'(k);
         if (idx > 5'd8) idx = idx - 5'd9;
         if (elig[idx[3:0]]) res = {1'b1, idx[3:0]};
      end
      return res;
   endfunction

   assign req_rise   = REQ & ~req_q;
   assign eligible   = pend & ~mask;
   assign next_start = (id == 4'd8) ? 4'd0 : id + 4'd1;

`ifdef IRQ_SCHED_RR_EN
   logic [3:0] rr_ptr, rr_ptr_nxt;

   assign pick_res = pick(eligible, rr_ptr);

   always_ff @(posedge CK) begin
      if (RST) rr_ptr <= '0;
      else     rr_ptr <= rr_ptr_nxt;
   end

   // Advance only when a grant ends, whether by ACK or by timeout.
   always_comb begin
      rr_ptr_nxt = rr_ptr;
      if (state == GRANT && (ACK || cnt == 8'(TIMEOUT - 1)))
         rr_ptr_nxt = next_start;
   end
`else
   assign pick_res = pick(eligible, 4'd0);
`endif

   always_comb begin
      state_nxt = state;
      id_nxt    = id;
      cnt_nxt   = cnt;
      tmo_nxt   = 1'b0;
      clr       = '0;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (pick_res[4]) begin
               state_nxt = GRANT;
               id_nxt    = pick_res[3:0];
            end else begin
               id_nxt = '0;
            end
         end
         GRANT: begin
            if (ACK) begin
               clr       = 9'd1 << id;
               state_nxt = IDLE;
               cnt_nxt   = '0;
               id_nxt    = '0;
            end else if (cnt == 8'(TIMEOUT - 1)) begin
               // This edge completes the TIMEOUT-th unacknowledged cycle.
               state_nxt = IDLE;
               cnt_nxt   = '0;
               id_nxt    = '0;
               tmo_nxt   = 1'b1;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // A fresh edge on the acknowledged channel outranks the clear.
      pend_nxt = (pend & ~clr) | req_rise;
   end

   always_ff @(posedge CK) begin
      if (RST) begin
         state <= IDLE;
         req_q <= '0;
         pend  <= '0;
         mask  <= 9'h1FF;
         id    <= '0;
         cnt   <= '0;
         TMO   <= 1'b0;
      end else begin
         state <= state_nxt;
         req_q <= REQ;
         pend  <= pend_nxt;
         if (MASK_WE) mask <= MASK_D;
         id    <= id_nxt;
         cnt   <= cnt_nxt;
         TMO   <= tmo_nxt;
      end
   end

   assign MASK_Q = mask;
   assign PEND   = pend;
   assign IRQ    = (state == GRANT);
   assign ID     = id;

endmodule
